vend_controller: RTL

Multi-product vending sequencer that sits between the coin acceptor, the selection keypad, the product dispenser and the change hopper. It accumulates credit from 1 rs and 2 rs coins and validates a product selection against per-product price and stock. It then runs a request/acknowledge handshake with the dispenser and pays out any remaining credit one coin at a time. It also supports cancel and an inactivity timeout that refunds all credit.

---
 rtl/vend_pkg.sv | 35 +++
 rtl/vend_change_unit.sv | 49 ++++
 rtl/vend_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types, coin encodings and price/coin helpers for the vending controller.
package vend_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Price table is packed as {p3, p2, p1, p0}, CREDIT_W bits each.
  function automatic logic [CREDIT_W-1:0] price_lookup(
    input logic [1:0]            id,
    input logic [4*CREDIT_W-1:0] tbl
  );
    return tbl[id*CREDIT_W +: CREDIT_W];
  endfunction

  // Rupee value of a coin code; invalid and empty codes are worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_1:  return CREDIT_W'(1);
      COIN_2:  return CREDIT_W'(2);
      default: return CREDIT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change payout: holds the remaining amount and offers one coin at a time
// to the hopper, largest coin first, with a one-cycle gap after each ack.
module vend_change_unit
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                change_ack,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] remain,
  output logic                done
);

  logic                active;
  logic [CREDIT_W-1:0] coin_val;

  assign coin_val = coin_value(change_coin);
  // Last coin of the payout is being acknowledged this cycle.
  assign done     = change_valid & change_ack & (remain == coin_val);

  // Offer/ack handshake; a fresh load always starts with change_valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      remain       <= '0;
      change_valid <= 1'b0;
      change_coin  <= COIN_NONE;
    end else if (load) begin
      active       <= (load_val != '0);
      remain       <= load_val;
      change_valid <= 1'b0;
    end else if (active) begin
      if (change_valid) begin
        if (change_ack) begin
          change_valid <= 1'b0;
          remain       <= remain - coin_val;
          if (done) active <= 1'b0;
        end
      end else begin
        change_valid <= 1'b1;
        change_coin  <= (remain >= CREDIT_W'(2)) ? COIN_2 : COIN_1;
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, selection check, dispense handshake,
// inactivity timeout and hand-off of leftover credit to the change unit.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 2,
  parameter int PRICE2      = 4,
  parameter int PRICE3      = 5,
  parameter int MAX_CREDIT  = 9,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic [3:0]          stock,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                sel_err,
  output logic                busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4*CREDIT_W-1:0] PRICE_TBL = {
    CREDIT_W'(PRICE3), CREDIT_W'(PRICE2), CREDIT_W'(PRICE1), CREDIT_W'(PRICE0)
  };

  state_t              state;
  logic [TMR_W-1:0]    tmr;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic                coin_ok, coin_bad, fits, sel_ok;
  logic                tmr_clr, tmr_hit, timeout;
  logic                chg_load, chg_done;
  logic [CREDIT_W-1:0] chg_remain;

  assign coin_val = coin_value(coin_in);
  assign coin_ok  = (coin_val != '0);
  assign coin_bad = (coin_in == COIN_BAD);
  // One extra bit so a ceiling of 15 plus a 2 rs coin is still compared correctly.
  assign sum      = {1'b0, credit} + {1'b0, coin_val};
  assign fits     = (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign price    = price_lookup(sel_id, PRICE_TBL);
  assign sel_ok   = stock[sel_id] && (credit >= price);
  // Idle time restarts on any accepted coin or any selection attempt.
  assign tmr_clr  = (coin_ok && fits) || sel_valid;
  assign tmr_hit  = (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign timeout  = !cancel && !tmr_clr && tmr_hit;

  // Change unit is loaded with the current credit on every entry to CHANGE.
  always_comb begin
    chg_load = 1'b0;
    case (state)
      S_CREDIT: chg_load = cancel || timeout;
      S_VEND:   chg_load = disp_ack && (credit != '0);
      default:  chg_load = 1'b0;
    endcase
  end

  vend_change_unit u_change (
    .clk          (clk),
    .rst          (rst),
    .load         (chg_load),
    .load_val     (credit),
    .change_ack   (change_ack),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .remain       (chg_remain),
    .done         (chg_done)
  );

  // Main FSM with registered outputs; credit doubles as "remain" in VEND/CHANGE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      credit   <= '0;
      tmr      <= '0;
      disp_req <= 1'b0;
      disp_id  <= 2'b00;
      coin_rej <= 1'b0;
      sel_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      coin_rej <= coin_bad;
      sel_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          sel_err <= sel_valid;
          if (coin_ok) begin
            credit <= coin_val;
            tmr    <= '0;
            state  <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel) begin
            // A coin arriving with cancel is handed back rather than swallowed.
            coin_rej <= coin_bad || coin_ok;
            sel_err  <= sel_valid;
            state    <= S_CHANGE;
            busy     <= 1'b1;
          end else begin
            if (coin_ok) begin
              if (fits) credit <= sum[CREDIT_W-1:0];
              else      coin_rej <= 1'b1;
              sel_err <= sel_valid;
            end else if (sel_valid) begin
              if (sel_ok) begin
                credit   <= credit - price;
                disp_req <= 1'b1;
                disp_id  <= sel_id;
                state    <= S_VEND;
                busy     <= 1'b1;
              end else begin
                sel_err <= 1'b1;
              end
            end
            if (tmr_clr) begin
              tmr <= '0;
            end else if (tmr_hit) begin
              tmr   <= '0;
              state <= S_CHANGE;
              busy  <= 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        S_VEND: begin
          coin_rej <= (coin_in != COIN_NONE);
          sel_err  <= sel_valid;
          if (disp_ack) begin
            disp_req <= 1'b0;
            if (credit != '0) begin
              state <= S_CHANGE;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_CHANGE: begin
          coin_rej <= (coin_in != COIN_NONE);
          sel_err  <= sel_valid;
          if (change_valid && change_ack)
            credit <= credit - coin_value(change_coin);
          if (chg_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
